// File: rtl/pp_pkg.sv
// Purpose : shared types and default sizing for the ping-pong bank sequencer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package pp_pkg;

  // Default geometry: one bank holds DEPTH words, addressed by ADDR_W bits.
  localparam int PP_DEPTH  = 512;
  localparam int PP_ADDR_W = 9;

  // Ownership of one bank. It cycles EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  // A 1-word block goes straight from EMPTY to FULL.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Read-side sequencer states.
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DRAIN = 2'd1,
    R_FLUSH = 2'd2
  } rd_state_t;

  // One-hot bank enable for a 1-bit bank select.
  function automatic logic [1:0] bank_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pp_valid_delay.sv
// Purpose : fixed-depth shift register carrying {valid, bank select} so that
//           the column valid and the data mux select line up with RAM read data.
// Latency : exactly LAT cycles from in_* to out_*.
// Backpr. : none; the pipeline always advances.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears the pipe)
//   in_valid, in_sel   read enable (OR-reduced) and bank select at issue time
//   out_valid, out_sel the same pair, delayed by LAT cycles
module pp_valid_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sel,
  output logic out_valid,
  output logic out_sel
);

  // pipe[0] is the youngest stage and pipe[LAT-1] is the output stage.
  logic [1:0] pipe [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe[i] <= 2'b00;
      end
    end else begin
      pipe[0] <= {in_valid, in_sel};
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign {out_valid, out_sel} = pipe[LAT-1];

endmodule

// File: rtl/pp_bank_ctrl.sv
// Purpose : ping-pong sequencer for two external bank RAMs feeding a systolic
//           array column. It drives only the RAM enables and addresses and
//           carries no data.
// Latency : a write enable is issued in the handshake cycle. The first read
//           enable comes 2 cycles after a pending start sees a FULL bank.
//           col_valid_in follows bank_re by RD_LAT.
// Backpr. : wr_ready is low while the bank being filled is still FULL or
//           DRAINING. The read side runs without stalls once it starts.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_last producer handshake; wr_last closes a block early
//   bank_we, bank_waddr       one-hot write enable and write address (combinational)
//   rd_start, rd_busy         consumer drain request (sticky) and drain in progress
//   bank_re, bank_raddr       one-hot read enable and read address (registered)
//   bank_rsel, col_valid_in   data mux select and column valid, aligned with RAM data
//   rd_done                   one-cycle pulse when a bank returns to EMPTY
//   full_flags, empty         per-bank FULL flags; both banks EMPTY
module pp_bank_ctrl
  import pp_pkg::*;
#(
  parameter int DEPTH  = PP_DEPTH,
  parameter int ADDR_W = PP_ADDR_W,   // must equal clog2(DEPTH)
  parameter int RD_LAT = 1            // bank RAM read latency, 1..3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_last,
  output logic [1:0]        bank_we,
  output logic [ADDR_W-1:0] bank_waddr,
  input  logic              rd_start,
  output logic              rd_busy,
  output logic [1:0]        bank_re,
  output logic              bank_rsel,
  output logic [ADDR_W-1:0] bank_raddr,
  output logic              col_valid_in,
  output logic              rd_done,
  output logic [1:0]        full_flags,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W + 1)'(1);
  localparam logic [1:0]        FLUSH_LAST = 2'(RD_LAT - 1);

  bank_state_t       bank_st [2];
  logic [ADDR_W:0]   len     [2];   // one extra bit so a full DEPTH block fits
  logic              wsel;
  logic              rsel;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] rcnt;
  rd_state_t         rd_st;
  logic              pending;
  logic [1:0]        fcnt;
  logic              re_sel;        // rsel registered alongside bank_re

  logic wr_hs;
  logic wr_close;
  logic rd_go;
  logic rd_last;

  // ---------------------------------------------------------------------------
  // Write side (combinational handshake).
  // Keeping wr_ready low during reset means a producer cannot write into a RAM
  // that is being reset.
  // ---------------------------------------------------------------------------
  assign wr_ready   = !rst && (bank_st[wsel] == EMPTY || bank_st[wsel] == FILLING);
  assign wr_hs      = wr_valid && wr_ready;
  assign wr_close   = wr_hs && (wr_last || wcnt == ADDR_LAST);
  assign bank_we    = wr_hs ? bank_onehot(wsel) : 2'b00;
  assign bank_waddr = wcnt;

  // ---------------------------------------------------------------------------
  // Read side decode.
  // The reader only starts on a registered FULL. A block that is closing in
  // this same cycle is therefore seen one cycle later, and the two sides never
  // update the same bank in one cycle.
  // ---------------------------------------------------------------------------
  assign rd_go   = (rd_st == R_IDLE) && pending && (bank_st[rsel] == FULL);
  assign rd_last = ({1'b0, rcnt} + LEN_ONE) == len[rsel];
  assign rd_busy = (rd_st != R_IDLE);

  assign full_flags = {bank_st[1] == FULL, bank_st[0] == FULL};
  assign empty      = (bank_st[0] == EMPTY) && (bank_st[1] == EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      len[0]     <= '0;
      len[1]     <= '0;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      rd_st      <= R_IDLE;
      pending    <= 1'b0;
      fcnt       <= '0;
      re_sel     <= 1'b0;
      bank_re    <= 2'b00;
      bank_raddr <= '0;
      rd_done    <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      bank_re <= 2'b00;

      // Write side: fill the selected bank, then close the block on wr_last or
      // on the last address. Writes never wrap.
      if (wr_close) begin
        len[wsel]     <= {1'b0, wcnt} + LEN_ONE;
        bank_st[wsel] <= FULL;
        wsel          <= ~wsel;
        wcnt          <= '0;
      end else if (wr_hs) begin
        bank_st[wsel] <= FILLING;
        wcnt          <= wcnt + ADDR_ONE;
      end

      // Requests that arrive during a drain are dropped and not queued.
      if (rd_start && !rd_busy) begin
        pending <= 1'b1;
      end

      case (rd_st)
        R_IDLE: begin
          if (rd_go) begin
            pending       <= 1'b0;
            bank_st[rsel] <= DRAINING;
            rcnt          <= '0;
            rd_st         <= R_DRAIN;
          end
        end

        R_DRAIN: begin
          bank_re    <= bank_onehot(rsel);
          bank_raddr <= rcnt;
          re_sel     <= rsel;
          rcnt       <= rcnt + ADDR_ONE;
          if (rd_last) begin
            fcnt  <= '0;
            rd_st <= R_FLUSH;
          end
        end

        // Hold the bank until its last read beat has come out of the RAM
        // pipeline. rd_done then coincides with the final col_valid_in beat.
        R_FLUSH: begin
          if (fcnt == FLUSH_LAST) begin
            bank_st[rsel] <= EMPTY;
            rd_done       <= 1'b1;
            rsel          <= ~rsel;
            rd_st         <= R_IDLE;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end

        default: rd_st <= R_IDLE;
      endcase
    end
  end

  // Match the bank RAM read latency for the column valid and the data mux select.
  pp_valid_delay #(
    .LAT (RD_LAT)
  ) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (|bank_re),
    .in_sel    (re_sel),
    .out_valid (col_valid_in),
    .out_sel   (bank_rsel)
  );

endmodule

// File: tb/tb_pp_bank_ctrl.sv
// Purpose : directed self-checking bench for pp_bank_ctrl.
// Latency : uses RD_LAT=2 so that the read-latency compensation is visible.
// Backpr. : the producer is held valid while the controller stalls it.
module tb_pp_bank_ctrl;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_last;
  logic [1:0]        bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic              rd_start;
  logic              rd_busy;
  logic [1:0]        bank_re;
  logic              bank_rsel;
  logic [ADDR_W-1:0] bank_raddr;
  logic              col_valid_in;
  logic              rd_done;
  logic [1:0]        full_flags;
  logic              empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pp_bank_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_last      (wr_last),
    .bank_we      (bank_we),
    .bank_waddr   (bank_waddr),
    .rd_start     (rd_start),
    .rd_busy      (rd_busy),
    .bank_re      (bank_re),
    .bank_rsel    (bank_rsel),
    .bank_raddr   (bank_raddr),
    .col_valid_in (col_valid_in),
    .rd_done      (rd_done),
    .full_flags   (full_flags),
    .empty        (empty)
  );

  // Inputs are driven on the falling edge. Outputs are sampled 1 time unit later.
  task automatic do_reset;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_words(input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_last  = last_at_end && (i == n - 1);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic pulse_rd_start;
    @(negedge clk);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_last  = 1'b0;
    rd_start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bank_we, bank_re, rd_busy, col_valid_in, rd_done, full_flags, bank_rsel, wr_ready} !== 12'b0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b re=%b busy=%b col=%b done=%b full=%b rsel=%b rdy=%b required all 0",
               bank_we, bank_re, rd_busy, col_valid_in, rd_done, full_flags, bank_rsel, wr_ready);
    end
    checks++;
    if (empty !== 1'b1 || bank_raddr !== '0 || bank_waddr !== '0) begin
      errors++;
      $display("FAIL reset_empty_addr: empty=%b raddr=%0d waddr=%0d required 1/0/0", empty, bank_raddr, bank_waddr);
    end
    wr_valid = 1'b0;
    rst      = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wr_ready: got %b required 1", wr_ready);
    end
  endtask

  task automatic test_basic_fill;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_last  = 1'b0;
      #1;
      checks++;
      if (wr_ready !== 1'b1 || bank_we !== 2'b01 || bank_waddr !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL fill_word %0d: rdy=%b we=%b addr=%0d required 1/01/%0d", i, wr_ready, bank_we, bank_waddr, i);
      end
    end
    @(negedge clk);
    wr_valid = 1'b1;
    #1;
    checks++;
    if (full_flags !== 2'b01) begin
      errors++;
      $display("FAIL fill_full_flags: got %b required 01", full_flags);
    end
    checks++;
    if (wr_ready !== 1'b1 || bank_we !== 2'b10 || bank_waddr !== '0) begin
      errors++;
      $display("FAIL fill_next_bank: rdy=%b we=%b addr=%0d required 1/10/0", wr_ready, bank_we, bank_waddr);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Drains the bank selected by exp_sel after a single rd_start pulse and checks
  // the enables, addresses, alignment and release for a block of exp_len words.
  task automatic test_drain_bank(input string tag, input bit exp_sel, input int exp_len);
    int re_n = 0, re_first = -1, col_n = 0, col_first = -1, col_last = -1;
    int done_n = 0, done_cyc = -1;
    logic [1:0] exp_re;
    exp_re = exp_sel ? 2'b10 : 2'b01;
    pulse_rd_start();
    for (int c = 0; c < DEPTH + 40; c++) begin
      @(negedge clk);
      #1;
      if (bank_re !== 2'b00) begin
        checks++;
        if (bank_re !== exp_re || bank_raddr !== ADDR_W'(re_n)) begin
          errors++;
          $display("FAIL %s_read beat %0d: re=%b addr=%0d required %b/%0d", tag, re_n, bank_re, bank_raddr, exp_re, re_n);
        end
        if (re_first < 0) re_first = c;
        re_n++;
      end
      if (col_valid_in === 1'b1) begin
        checks++;
        if (bank_rsel !== exp_sel) begin
          errors++;
          $display("FAIL %s_rsel beat %0d: got %b required %b", tag, col_n, bank_rsel, exp_sel);
        end
        if (col_first < 0) col_first = c;
        col_last = c;
        col_n++;
      end
      if (rd_done === 1'b1) begin
        done_n++;
        done_cyc = c;
      end
    end
    checks++;
    if (re_n !== exp_len) begin
      errors++;
      $display("FAIL %s_re_count: got %0d required %0d", tag, re_n, exp_len);
    end
    checks++;
    if (col_n !== exp_len || col_last - col_first + 1 !== exp_len) begin
      errors++;
      $display("FAIL %s_col_count: beats=%0d span=%0d required %0d", tag, col_n, col_last - col_first + 1, exp_len);
    end
    checks++;
    if (col_first - re_first !== RD_LAT) begin
      errors++;
      $display("FAIL %s_col_latency: got %0d required %0d", tag, col_first - re_first, RD_LAT);
    end
    checks++;
    if (done_n !== 1 || done_cyc !== col_last) begin
      errors++;
      $display("FAIL %s_rd_done: pulses=%0d at %0d required 1 at %0d", tag, done_n, done_cyc, col_last);
    end
    checks++;
    if (rd_busy !== 1'b0 || full_flags[exp_sel] !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: busy=%b full=%b required busy 0 and bank %0d not full", tag, rd_busy, full_flags, exp_sel);
    end
  endtask

  task automatic test_drain;
    test_drain_bank("drain", 1'b0, DEPTH);
    checks++;
    if (full_flags !== 2'b00 || empty !== 1'b0) begin
      errors++;
      $display("FAIL drain_flags: full=%b empty=%b required 00/0", full_flags, empty);
    end
  endtask

  task automatic test_short_block;
    int col_n = 0;
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_last  = (i == 4);
      #1;
      checks++;
      if (bank_we !== 2'b01 || bank_waddr !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL short_word %0d: we=%b addr=%0d required 01/%0d", i, bank_we, bank_waddr, i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_last  = 1'b0;
      #1;
      checks++;
      if (bank_we !== 2'b10 || bank_waddr !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL short_bank1_word %0d: we=%b addr=%0d required 10/%0d", i, bank_we, bank_waddr, i);
      end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      #1;
      checks++;
      if (wr_ready !== 1'b0 || bank_we !== 2'b00 || full_flags !== 2'b11) begin
        errors++;
        $display("FAIL short_stall: rdy=%b we=%b full=%b required 0/00/11", wr_ready, bank_we, full_flags);
      end
    end
    @(negedge clk);
    rd_start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rd_start = 1'b0;
      #1;
      if (col_valid_in === 1'b1) begin
        col_n++;
        checks++;
        if (bank_rsel !== 1'b0) begin
          errors++;
          $display("FAIL short_rsel: got %b required 0", bank_rsel);
        end
      end
      checks++;
      if (rd_done === 1'b1) begin
        seen = 1;
        if (wr_ready !== 1'b1 || bank_we !== 2'b01 || bank_waddr !== '0) begin
          errors++;
          $display("FAIL short_resume: rdy=%b we=%b addr=%0d required 1/01/0", wr_ready, bank_we, bank_waddr);
        end
        break;
      end else if (wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL short_hold: wr_ready=%b before rd_done required 0", wr_ready);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL short_timeout: rd_done seen=%0d required 1", seen);
    end
    checks++;
    if (col_n !== 5) begin
      errors++;
      $display("FAIL short_beats: got %0d required 5", col_n);
    end
  endtask

  // Bank 1, which was filled during the short-block test, now drains on bank 1.
  task automatic test_back_to_back;
    test_drain_bank("b2b", 1'b1, DEPTH);
    checks++;
    if (wr_ready !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL b2b_state: rdy=%b empty=%b required 1/0", wr_ready, empty);
    end
  endtask

  task automatic test_early_start;
    int col_n = 0, done_n = 0;
    do_reset();
    pulse_rd_start();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rd_busy !== 1'b0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL early_idle: busy=%b empty=%b required 0/1", rd_busy, empty);
      end
    end
    write_words(3, 1'b1);
    #1;
    checks++;
    if (full_flags !== 2'b01 || rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL early_full: full=%b busy=%b required 01/0", full_flags, rd_busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rd_busy !== 1'b1 || full_flags !== 2'b00) begin
      errors++;
      $display("FAIL early_autostart: busy=%b full=%b required 1/00", rd_busy, full_flags);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (col_valid_in === 1'b1) col_n++;
      if (rd_done === 1'b1) done_n++;
    end
    checks++;
    if (col_n !== 3 || done_n !== 1) begin
      errors++;
      $display("FAIL early_drain: beats=%0d done=%0d required 3/1", col_n, done_n);
    end
  endtask

  task automatic test_reset_mid_drain;
    bit found = 0;
    do_reset();
    write_words(DEPTH, 1'b0);
    pulse_rd_start();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (bank_re === 2'b01 && bank_raddr === ADDR_W'(100)) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_reach_addr100: found=%0d required 1", found);
    end
    rst      = 1'b1;
    wr_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bank_we !== 2'b00 || bank_re !== 2'b00 || col_valid_in !== 1'b0 || empty !== 1'b1 || rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: we=%b re=%b col=%b empty=%b busy=%b required 00/00/0/1/0",
               bank_we, bank_re, col_valid_in, empty, rd_busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || bank_we !== 2'b01 || bank_waddr !== '0) begin
      errors++;
      $display("FAIL midrst_next_block: rdy=%b we=%b addr=%0d required 1/01/0", wr_ready, bank_we, bank_waddr);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_drain();
    test_short_block();
    test_back_to_back();
    test_early_start();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
